// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core front end: word types, the DAT opcode,
// the NOP word and the fetch state encoding.
package core_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [3:0] CORE_DAT_OPCODE = 4'hF;
  localparam word_t      CORE_NOP_WORD   = 16'h0000;
  localparam addr_t      CORE_RESET_PC   = 16'h0000;

  typedef enum logic {FETCH, DAT_IMM} fetch_state_e;

  function automatic logic [3:0] opcode_of(input word_t w);
    return w[15:12];
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode/execute controls and the IF/ID packet.
interface fetch_stage_if;
  import core_pkg::*;

  addr_t imem_addr;
  word_t imem_inst;
  logic  stall;
  logic  redirect;
  addr_t redirect_pc;
  logic  id_valid;
  word_t id_inst;
  addr_t id_pc;
  word_t id_imm;
  logic  id_is_dat;
  logic [15:0] fetch_count;

  modport master (
    output imem_addr, id_valid, id_inst, id_pc, id_imm, id_is_dat, fetch_count,
    input  imem_inst, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, id_valid, id_inst, id_pc, id_imm, id_is_dat, fetch_count,
    output imem_inst, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect beats stall beats increment; wraps modulo 2^16.
module fetch_pc_reg
  import core_pkg::*;
#(
  parameter addr_t RESET_PC = CORE_RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_redirect,
  input  addr_t i_redirect_pc,
  input  logic  i_stall,
  output addr_t o_pc
);
  addr_t r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_pc <= RESET_PC;
    else if (i_redirect) r_pc <= i_redirect_pc;
    else if (!i_stall)   r_pc <= r_pc + 16'd1;
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, registers fetched words into IF/ID and merges the
// two-word DAT instruction into a single decode packet.
module fetch_stage
  import core_pkg::*;
#(
  parameter addr_t      RESET_PC   = CORE_RESET_PC,
  parameter logic [3:0] DAT_OPCODE = CORE_DAT_OPCODE,
  parameter word_t      NOP_WORD   = CORE_NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  addr_t        w_pc;
  fetch_state_e r_state, w_state_nxt;
  logic         w_issue_plain, w_issue_dat, w_capture;

  word_t       r_hold_inst;
  addr_t       r_hold_pc;
  logic        r_id_valid;
  word_t       r_id_inst;
  addr_t       r_id_pc;
  word_t       r_id_imm;
  logic        r_id_is_dat;
  logic [15:0] r_fetch_count;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (bus.redirect),
    .i_redirect_pc (bus.redirect_pc),
    .i_stall       (bus.stall),
    .o_pc          (w_pc)
  );

  assign bus.imem_addr = w_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // The literal word fetched in DAT_IMM is never decoded, whatever it looks like.
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_plain = 1'b0;
    w_issue_dat   = 1'b0;
    w_capture     = 1'b0;
    if (bus.redirect) begin
      w_state_nxt = FETCH;
    end else if (!bus.stall) begin
      case (r_state)
        FETCH: begin
          if (opcode_of(bus.imem_inst) == DAT_OPCODE) begin
            w_capture   = 1'b1;
            w_state_nxt = DAT_IMM;
          end else begin
            w_issue_plain = 1'b1;
          end
        end
        DAT_IMM: begin
          w_issue_dat = 1'b1;
          w_state_nxt = FETCH;
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_inst   <= '0;
      r_hold_pc     <= '0;
      r_id_valid    <= 1'b0;
      r_id_inst     <= NOP_WORD;
      r_id_pc       <= '0;
      r_id_imm      <= '0;
      r_id_is_dat   <= 1'b0;
      r_fetch_count <= '0;
    end else if (bus.redirect) begin
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_WORD;
      r_id_is_dat <= 1'b0;
    end else if (w_issue_plain) begin
      r_id_valid    <= 1'b1;
      r_id_inst     <= bus.imem_inst;
      r_id_pc       <= w_pc;
      r_id_imm      <= '0;
      r_id_is_dat   <= 1'b0;
      r_fetch_count <= r_fetch_count + 16'd1;
    end else if (w_issue_dat) begin
      r_id_valid    <= 1'b1;
      r_id_inst     <= r_hold_inst;
      r_id_pc       <= r_hold_pc;
      r_id_imm      <= bus.imem_inst;
      r_id_is_dat   <= 1'b1;
      r_fetch_count <= r_fetch_count + 16'd1;
    end else if (w_capture) begin
      // First DAT word parks in the holding register; decode sees one bubble.
      r_hold_inst <= bus.imem_inst;
      r_hold_pc   <= w_pc;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_WORD;
      r_id_imm    <= '0;
      r_id_is_dat <= 1'b0;
    end
  end

  assign bus.id_valid    = r_id_valid;
  assign bus.id_inst     = r_id_inst;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_imm      = r_id_imm;
  assign bus.id_is_dat   = r_id_is_dat;
  assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a small behavioural ROM.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h9201;
      16'h0001: return 16'h9402;
      16'h0006: return 16'hF640;
      16'h0007: return 16'h1857;
      16'h0008: return 16'h1A58;
      16'hFFFF: return 16'hF123;
      default:  return 16'h0000;
    endcase
  endfunction

  assign bus.imem_inst = rom(bus.imem_addr);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pkt(input string tag, input logic v, input logic [15:0] pc,
                     input logic [15:0] inst, input logic [15:0] imm, input logic dat);
    chk({tag, ".valid"}, {15'd0, bus.id_valid}, {15'd0, v});
    chk({tag, ".pc"},    bus.id_pc, pc);
    chk({tag, ".inst"},  bus.id_inst, inst);
    chk({tag, ".imm"},   bus.id_imm, imm);
    chk({tag, ".dat"},   {15'd0, bus.id_is_dat}, {15'd0, dat});
  endtask

  task automatic redir(input logic [15:0] tgt);
    bus.redirect = 1'b1;
    bus.redirect_pc = tgt;
    step();
    bus.redirect = 1'b0;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst.addr", bus.imem_addr, 16'h0000);
    chk("rst.cnt", bus.fetch_count, 16'h0000);
    pkt("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;

    // Straight-line fetch of six plain words
    step(); pkt("p0", 1'b1, 16'h0000, 16'h9201, 16'h0000, 1'b0);
    step(); pkt("p1", 1'b1, 16'h0001, 16'h9402, 16'h0000, 1'b0);
    for (int i = 2; i < 6; i++) begin
      step(); pkt("pz", 1'b1, 16'(i), 16'h0000, 16'h0000, 1'b0);
    end
    chk("cnt6", bus.fetch_count, 16'd6);

    // DAT at 6: bubble, merged packet, then 1A58 at 8
    step(); chk("bub.valid", {15'd0, bus.id_valid}, 16'd0);
    chk("bub.addr", bus.imem_addr, 16'h0007);
    step(); pkt("dat6", 1'b1, 16'h0006, 16'hF640, 16'h1857, 1'b1);
    chk("dat6.addr", bus.imem_addr, 16'h0008);
    step(); pkt("p8", 1'b1, 16'h0008, 16'h1A58, 16'h0000, 1'b0);
    chk("p8.addr", bus.imem_addr, 16'h0009);
    chk("cnt8", bus.fetch_count, 16'd8);

    // Stall for three cycles with 9402 in IF/ID
    redir(16'h0000);
    chk("rd0.valid", {15'd0, bus.id_valid}, 16'd0);
    step(); step();
    pkt("pre", 1'b1, 16'h0001, 16'h9402, 16'h0000, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl.addr", bus.imem_addr, 16'h0002);
      chk("stl.cnt", bus.fetch_count, 16'd10);
      pkt("stl", 1'b1, 16'h0001, 16'h9402, 16'h0000, 1'b0);
    end
    bus.stall = 1'b0;
    step(); pkt("rel", 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b0);
    chk("rel.cnt", bus.fetch_count, 16'd11);
    chk("rel.addr", bus.imem_addr, 16'h0003);

    // Redirect beats stall
    bus.stall = 1'b1;
    redir(16'h0006);
    bus.stall = 1'b0;
    chk("rs.addr", bus.imem_addr, 16'h0006);
    chk("rs.valid", {15'd0, bus.id_valid}, 16'd0);
    chk("rs.cnt", bus.fetch_count, 16'd11);
    step(); chk("rs.bub", {15'd0, bus.id_valid}, 16'd0);
    step(); pkt("rs.dat", 1'b1, 16'h0006, 16'hF640, 16'h1857, 1'b1);

    // Redirect while in DAT_IMM abandons the partial DAT
    redir(16'h0006);
    step(); chk("ab.addr", bus.imem_addr, 16'h0007);
    redir(16'h0000);
    chk("ab.valid", {15'd0, bus.id_valid}, 16'd0);
    chk("ab.isdat", {15'd0, bus.id_is_dat}, 16'd0);
    step(); pkt("ab.p0", 1'b1, 16'h0000, 16'h9201, 16'h0000, 1'b0);
    chk("ab.cnt", bus.fetch_count, 16'd13);

    // Asynchronous reset mid-DAT_IMM
    redir(16'h0006);
    step(); chk("ar.addr0", bus.imem_addr, 16'h0007);
    rst = 1'b1;
    #1;
    chk("ar.addr", bus.imem_addr, 16'h0000);
    chk("ar.cnt", bus.fetch_count, 16'h0000);
    pkt("ar", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // DAT at FFFF takes its literal from 0000
    redir(16'hFFFF);
    chk("wr.addr", bus.imem_addr, 16'hFFFF);
    step(); chk("wr.bub", {15'd0, bus.id_valid}, 16'd0);
    chk("wr.addr0", bus.imem_addr, 16'h0000);
    step(); pkt("wr.dat", 1'b1, 16'hFFFF, 16'hF123, 16'h9201, 1'b1);
    chk("wr.addr1", bus.imem_addr, 16'h0001);
    chk("wr.cnt", bus.fetch_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
